// File: rtl/neuron_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : neuron_sequencer
// Purpose  : Sequences one neuron evaluation. It accepts N_INPUTS (x, w)
//            pairs over a valid/ready stream and accumulates the Q(FRAC_W)
//            fixed-point products. It then adds a latched bias and offers
//            the result on a valid/ready output.
// Ports    : CLK        - rising-edge clock
//            reset      - synchronous, active-low reset
//            start      - begin an evaluation (sampled only in IDLE)
//            bias       - signed bias, latched on the accepted start
//            in_valid   - x_in/w_in valid
//            in_ready   - pair accepted this cycle (LOAD state)
//            x_in, w_in - signed activation / weight
//            busy       - evaluation in progress (state != IDLE)
//            out_valid  - y_out valid
//            out_ready  - downstream accepts y_out
//            y_out      - signed neuron result
// Config   : define RELU_EN to clamp negative results to zero on y_out.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_sequencer #(
    parameter int DATA_W   = 32,
    parameter int N_INPUTS = 4,
    parameter int CNT_W    = 3,
    parameter int FRAC_W   = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] w_in,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BIAS = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int               c_pw   = DATA_W + FRAC_W;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(N_INPUTS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_bias_q;
    logic [DATA_W-1:0] r_y;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_out_valid;

    logic              w_hs;
    logic              w_out_hs;
    logic              w_last;
    logic [c_pw-1:0]   w_xe;
    logic [c_pw-1:0]   w_we;
    logic [c_pw-1:0]   w_prod;
    logic [DATA_W-1:0] w_term;
    logic [DATA_W-1:0] w_y_next;
    logic              w_unused_frac;

    assign w_hs     = in_valid & r_in_ready;
    assign w_out_hs = r_out_valid & out_ready;
    assign w_last   = (r_cnt == c_last);

    // Only bits [FRAC_W +: DATA_W] of the full signed product survive the
    // arithmetic shift and truncation. The low DATA_W+FRAC_W bits of the
    // product of sign-extended operands are exact, so a narrower multiply
    // suffices.
    assign w_xe          = {{FRAC_W{x_in[DATA_W-1]}}, x_in};
    assign w_we          = {{FRAC_W{w_in[DATA_W-1]}}, w_in};
    assign w_prod        = w_xe * w_we;
    assign w_term        = w_prod[FRAC_W +: DATA_W];
    assign w_unused_frac = ^w_prod[FRAC_W-1:0];

`ifdef RELU_EN
    assign w_y_next = r_acc[DATA_W-1] ? '0 : r_acc;
`else
    assign w_y_next = r_acc;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)           w_state_nxt = ST_LOAD;
            ST_LOAD: if (w_hs && w_last)  w_state_nxt = ST_BIAS;
            ST_BIAS:                      w_state_nxt = ST_DONE;
            ST_DONE: if (w_out_hs)        w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_bias_q    <= '0;
            r_y         <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            // Flopped from the next state so they equal a decode of the
            // state register without any combinational path from inputs.
            r_in_ready <= (w_state_nxt == ST_LOAD);
            r_busy     <= (w_state_nxt != ST_IDLE);

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_bias_q <= bias;
                    end
                end
                ST_LOAD: begin
                    if (w_hs) begin
                        r_acc <= r_acc + w_term;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_BIAS: begin
                    r_acc <= r_acc + r_bias_q;
                end
                ST_DONE: begin
                    // The first DONE cycle captures the final accumulator.
                    // Afterwards y_out is held until the transfer completes.
                    if (!r_out_valid) begin
                        r_y         <= w_y_next;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign y_out     = r_y;

endmodule
`default_nettype wire

// File: tb/tb_neuron_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_sequencer
// Purpose  : Directed self-checking bench for neuron_sequencer. It checks
//            reset values, accumulation, valid gaps, negative products with
//            bias, output back-pressure with an ignored start, and abort by
//            reset.
// Config   : RELU_EN selects the clamped expectation for the negative case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_sequencer;

    logic        CLK       = 1'b0;
    logic        reset     = 1'b0;
    logic        start     = 1'b0;
    logic [31:0] bias      = '0;
    logic        in_valid  = 1'b0;
    logic [31:0] x_in      = '0;
    logic [31:0] w_in      = '0;
    logic        out_ready = 1'b0;
    wire         in_ready;
    wire         busy;
    wire         out_valid;
    wire  [31:0] y_out;

    int checks = 0;
    int errors = 0;
    int hs     = 0;
    int hs0    = 0;

    logic [31:0] xs[4];
    logic [31:0] ws[4];
    logic [31:0] exp_neg;

    neuron_sequencer #(
        .DATA_W  (32),
        .N_INPUTS(4),
        .CNT_W   (3),
        .FRAC_W  (16)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .start    (start),
        .bias     (bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .w_in     (w_in),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y_out    (y_out)
    );

    always #5 CLK = ~CLK;

    // Count accepted pairs as seen on the interface.
    always @(posedge CLK) begin
        if (in_valid && in_ready) hs <= hs + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] b);
        start = 1'b1;
        bias  = b;
        tick();
        start = 1'b0;
        bias  = 32'hDEAD_BEEF;   // must have been latched already
    endtask

    // Presents the four pairs; with gaps, an invalid cycle carrying junk
    // data precedes every pair.
    task automatic feed(input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                x_in     = 32'h7FFF_0000;
                w_in     = 32'h7FFF_0000;
                tick();
            end
            in_valid = 1'b1;
            x_in     = xs[i];
            w_in     = ws[i];
            tick();
        end
        in_valid = 1'b0;
        x_in     = '0;
        w_in     = '0;
    endtask

    // Called #1 after the last handshake edge.
    task automatic result(input string tag, input logic [31:0] exp, input bit drain);
        chk({tag, "_inready_drop"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_ov_t1"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({tag, "_ov_t1b"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({tag, "_ov_t2"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_y"}, y_out, exp);
        if (drain) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, "_ov_after"}, {31'd0, out_valid}, 32'd0);
            chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
            chk({tag, "_y_kept"}, y_out, exp);
        end
    endtask

    task automatic load_ramp;
        for (int i = 0; i < 4; i++) begin
            xs[i] = (i + 1) << 16;
            ws[i] = (i + 1) << 16;
        end
    endtask

    initial begin
`ifdef RELU_EN
        exp_neg = 32'h0000_0000;
`else
        exp_neg = 32'hFFFB_0000;
`endif
        // Reset values
        reset = 1'b0;
        tick();
        tick();
        chk("rst_y", y_out, 32'd0);
        chk("rst_inready", {31'd0, in_ready}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick();

        // 1.0^2 + 2.0^2 + 3.0^2 + 4.0^2 = 30.0
        load_ramp();
        hs0 = hs;
        do_start(32'd0);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        chk("t2_inready", {31'd0, in_ready}, 32'd1);
        feed(1'b0);
        chk("t2_hs", hs - hs0, 32'd4);
        result("t2", 32'h001E_0000, 1'b1);

        // Same data with in_valid toggling
        hs0 = hs;
        do_start(32'd0);
        feed(1'b1);
        chk("t3_hs", hs - hs0, 32'd4);
        result("t3", 32'h001E_0000, 1'b1);

        // -2.0 * 3.0 + 1.0 = -5.0
        xs[0] = 32'hFFFE_0000; ws[0] = 32'h0003_0000;
        for (int i = 1; i < 4; i++) begin
            xs[i] = '0;
            ws[i] = '0;
        end
        do_start(32'h0001_0000);
        feed(1'b0);
        result("t4", exp_neg, 1'b1);

        // Back-pressure in DONE with start pulsed throughout
        load_ramp();
        do_start(32'd0);
        feed(1'b0);
        result("t5", 32'h001E_0000, 1'b0);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_ov", {31'd0, out_valid}, 32'd1);
            chk("t5_hold_y", y_out, 32'h001E_0000);
        end
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        chk("t5_ov_done", {31'd0, out_valid}, 32'd0);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("t5_no_restart", {31'd0, busy}, 32'd0);

        // Abort by reset after two pairs, then a clean run
        do_start(32'h0005_0000);
        in_valid = 1'b1;
        x_in = xs[0]; w_in = ws[0];
        tick();
        x_in = xs[1]; w_in = ws[1];
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        tick();
        chk("t1_y", y_out, 32'd0);
        chk("t1_inready", {31'd0, in_ready}, 32'd0);
        chk("t1_ov", {31'd0, out_valid}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick();
        hs0 = hs;
        do_start(32'd0);
        feed(1'b0);
        chk("t6_hs", hs - hs0, 32'd4);
        result("t6", 32'h001E_0000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
